// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: FSM state encoding and counter widths/limits.
package stopwatch_pkg;

  localparam int unsigned SEC_W           = 6;
  localparam int unsigned SEC_MAX_DEFAULT = 59;
  localparam int unsigned MIN_MAX         = 99;

  // Start/stop/clear control states (2-bit encoding).
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

endpackage

// File: rtl/stopwatch_seconds_stage_tick_prescaler.sv
// tick_prescaler: divides clk by DIV while run is high.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous reset, active-high
//   run  - count enable; counter holds its value when low
//   clr  - synchronous clear of the counter
//   tick - high in the cycle whose rising edge wraps the counter (run && cnt==DIV-1)
module tick_prescaler #(
  parameter int unsigned DIV = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int unsigned     CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = run && (cnt == LAST);

  // Counter holds outside run so a paused fraction survives a resume.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/stopwatch_seconds_stage.sv
// stopwatch_seconds_stage: 1 Hz tick generation, seconds counter 0..SEC_MAX and
// the start/stop/clear FSM feeding the minutes counter on the same clock edge.
// Optional lap capture is built when STOPWATCH_LAP_EN is defined.
// Ports:
//   clk, rst        - system clock, asynchronous active-high reset
//   start_stop_btn  - debounced level; rising edge toggles run/pause
//   clear_btn       - debounced level; rising edge clears to IDLE (wins over start_stop)
//   lap_btn         - debounced level; rising edge in RUN toggles lap capture
//   en              - high while in RUN (minutes counter enable)
//   sync_reset      - one-cycle clear pulse (minutes counter sync reset)
//   sec_count       - current seconds value
//   sec_max_tick    - high in the cycle whose edge wraps seconds to 0
//   lap_sec         - captured seconds value
//   lap_hold        - lap capture valid
module stopwatch_seconds_stage
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned TICK_HZ     = 1,
  parameter int unsigned SEC_MAX     = SEC_MAX_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_stop_btn,
  input  logic             clear_btn,
  input  logic             lap_btn,
  output logic             en,
  output logic             sync_reset,
  output logic [SEC_W-1:0] sec_count,
  output logic             sec_max_tick,
  output logic [SEC_W-1:0] lap_sec,
  output logic             lap_hold
);

  localparam int unsigned      DIV      = CLK_FREQ_HZ / TICK_HZ;
  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SEC_MAX);

  state_e state;
  logic   ss_q;
  logic   clr_q;
  logic   ss_press;
  logic   clr_press;
  logic   tick;

  assign ss_press     = start_stop_btn & ~ss_q;
  assign clr_press    = clear_btn & ~clr_q;
  assign en           = (state == ST_RUN);
  assign sync_reset   = clr_press;
  assign sec_max_tick = tick && (sec_count == SEC_LAST);

  tick_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .run  (en),
    .clr  (clr_press),
    .tick (tick)
  );

  // Control FSM, button history and seconds counter.
  // A start_stop press on a tick cycle still lets that tick count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      ss_q      <= 1'b0;
      clr_q     <= 1'b0;
      sec_count <= '0;
    end else begin
      ss_q  <= start_stop_btn;
      clr_q <= clear_btn;
      if (clr_press) begin
        state     <= ST_IDLE;
        sec_count <= '0;
      end else begin
        if (ss_press) begin
          case (state)
            ST_IDLE:  state <= ST_RUN;
            ST_RUN:   state <= ST_PAUSE;
            ST_PAUSE: state <= ST_RUN;
            default:  state <= ST_IDLE;
          endcase
        end
        if (tick) begin
          sec_count <= (sec_count == SEC_LAST) ? '0 : sec_count + SEC_W'(1);
        end
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic lap_q;
  logic lap_press;

  assign lap_press = lap_btn & ~lap_q;

  // First lap press in RUN freezes the current seconds, the next releases it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lap_q    <= 1'b0;
      lap_sec  <= '0;
      lap_hold <= 1'b0;
    end else begin
      lap_q <= lap_btn;
      if (clr_press) begin
        lap_sec  <= '0;
        lap_hold <= 1'b0;
      end else if (lap_press && (state == ST_RUN)) begin
        if (lap_hold) begin
          lap_hold <= 1'b0;
        end else begin
          lap_sec  <= sec_count;
          lap_hold <= 1'b1;
        end
      end
    end
  end
`else
  logic lap_btn_unused;

  assign lap_btn_unused = lap_btn;
  assign lap_sec        = '0;
  assign lap_hold       = 1'b0;
`endif

endmodule
